// File: rtl/dmem_arbiter_if.sv
// Requester-side data-memory port: a request bundle plus its grant and read response.
// Latency: none, this is plain wiring. A read response arrives one cycle after its grant.
// Backpressure: the requester holds req/we/addr/wdata/be stable until gnt is seen high.
//
// Signals:
//   req    requester -> arbiter  request valid
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data, already lane-aligned
//   be     requester -> arbiter  byte enables
//   gnt    arbiter -> requester  request accepted this cycle
//   rvalid arbiter -> requester  read data valid
//   rdata  arbiter -> requester  raw read word
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic                    req;
    logic                    we;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] be;
    logic                    gnt;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    // Requester side (CPU memory stage, loader/debug path).
    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    // Arbiter side.
    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one synchronous byte-enabled RAM port between the CPU and the loader/debug path.
// The grant is combinational in the request cycle; read data returns on the requester's
// rvalid one cycle after the grant. The CPU has fixed priority. A loader that has been
// denied STARVE_LIMIT times in a row wins on the next cycle.
//
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   c_port          CPU requester port (slave side)
//   l_port          loader/debug requester port (slave side)
//   o_mem_addr      RAM word address
//   o_mem_wdata     RAM write data
//   o_mem_be        RAM byte enables, zero when nothing is granted
//   o_mem_wren      RAM write enable
//   i_mem_q         RAM read data, valid the cycle after the address is presented
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    dmem_arbiter_if.slave           c_port,
    dmem_arbiter_if.slave           l_port,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    output logic                    o_mem_wren,
    input  logic [DATA_WIDTH-1:0]   i_mem_q
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = 4;   // holds STARVE_LIMIT values up to 15
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_starve_cnt;   // consecutive loader denials
    logic             r_rsp_pend;     // a read was granted last cycle
    logic             r_rsp_src;      // owner of that read: 0 = CPU, 1 = loader

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic             w_both;
    logic             w_force_l;
    logic             w_c_win;
    logic             w_l_win;
    logic             w_grant;
    logic             w_sel_we;
    logic [BE_W-1:0]  w_sel_be;

    assign w_both    = c_port.req & l_port.req;
    assign w_force_l = (r_starve_cnt >= LIMIT);

    // Reset masks both grants so nothing reaches the RAM while reset is held.
    assign w_c_win = ~i_rst & c_port.req & (~l_port.req | ~w_force_l);
    assign w_l_win = ~i_rst & l_port.req & (~c_port.req |  w_force_l);
    assign w_grant = w_c_win | w_l_win;

    assign c_port.gnt = w_c_win;
    assign l_port.gnt = w_l_win;

    // ------------------------------------------------------------------
    // RAM port mux. Address and data fall back to the CPU inputs when idle;
    // they are don't-care then, because be and wren are both forced low.
    // ------------------------------------------------------------------
    assign w_sel_we    = w_l_win ? l_port.we    : c_port.we;
    assign w_sel_be    = w_l_win ? l_port.be    : c_port.be;
    assign o_mem_addr  = w_l_win ? l_port.addr  : c_port.addr;
    assign o_mem_wdata = w_l_win ? l_port.wdata : c_port.wdata;
    assign o_mem_be    = w_grant ? w_sel_be : '0;
    assign o_mem_wren  = w_grant & w_sel_we;

    // ------------------------------------------------------------------
    // Starvation counter: counts only the cycles in which the loader asks
    // and loses to the CPU. Any other cycle clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (w_both && !w_l_win) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Read response tracking. One entry suffices: RAM latency is a single
    // cycle, so each response leaves before the next one could collide.
    // The source bit is loaded every cycle; it is only used when pend is set.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rsp_pend <= 1'b0;
            r_rsp_src  <= 1'b0;
        end else begin
            r_rsp_pend <= w_grant & ~w_sel_we;
            r_rsp_src  <= w_l_win;
        end
    end

    // A read granted just before reset rises would otherwise still show its
    // response during the first reset cycle; gating with i_rst drops it.
    assign c_port.rvalid = r_rsp_pend & ~r_rsp_src & ~i_rst;
    assign l_port.rvalid = r_rsp_pend &  r_rsp_src & ~i_rst;

    // Both requesters see the raw word; lane select and sign extension stay upstream.
    assign c_port.rdata = i_mem_q;
    assign l_port.rdata = i_mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural one-cycle byte-enabled RAM.
// Inputs are driven on the falling edge; outputs are checked 1 ns later.
// All expected values are written into the stimulus by hand.
module tb_dmem_arbiter;

    localparam int DW = 32;
    localparam int AW = 15;

    logic          clk;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_wren;
    logic [DW-1:0] mem_q;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c_if ();
    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) l_if ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .c_port      (c_if),
        .l_port      (l_if),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_be    (mem_be),
        .o_mem_wren  (mem_wren),
        .i_mem_q     (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, one-cycle registered read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        mem_q <= ram[mem_addr];
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv_c(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        c_if.req = req; c_if.we = we; c_if.addr = a; c_if.wdata = d; c_if.be = be;
    endtask

    task automatic drv_l(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [3:0] be);
        l_if.req = req; l_if.we = we; l_if.addr = a; l_if.wdata = d; l_if.be = be;
    endtask

    task automatic idle();
        drv_c(1'b0, 1'b0, '0, '0, 4'h0);
        drv_l(1'b0, 1'b0, '0, '0, 4'h0);
    endtask

    // Checks both rvalids and, when one is expected, the data on that port.
    task automatic chk_rsp(input string tag, input logic cv, input logic lv, input logic [31:0] d);
        chk({tag, " c_rvalid"}, {31'b0, c_if.rvalid}, {31'b0, cv});
        chk({tag, " l_rvalid"}, {31'b0, l_if.rvalid}, {31'b0, lv});
        if (cv) chk({tag, " c_rdata"}, c_if.rdata, d);
        if (lv) chk({tag, " l_rdata"}, l_if.rdata, d);
    endtask

    task automatic chk_gnt(input string tag, input logic cg, input logic lg);
        chk({tag, " c_gnt"}, {31'b0, c_if.gnt}, {31'b0, cg});
        chk({tag, " l_gnt"}, {31'b0, l_if.gnt}, {31'b0, lg});
    endtask

    initial begin
        logic exp_c;
        logic prev_c;

        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram[15'h005] = 32'h1234_5678;
        ram[15'h020] = 32'hC0DE_0020;
        ram[15'h030] = 32'h1DAD_0030;
        for (int k = 0; k < 6; k++) ram[15'h040 + k] = 32'hA500_0000 | k;

        rst = 1'b1;
        idle();

        // Reset held with both requesters active.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv_c(1'b1, 1'b0, 15'h005, '0, 4'h0);
            drv_l(1'b1, 1'b0, 15'h030, '0, 4'h0);
            #1;
            chk_gnt("reset", 1'b0, 1'b0);
            chk("reset mem_wren", {31'b0, mem_wren}, 32'h0);
            chk("reset mem_be", {28'b0, mem_be}, 32'h0);
            chk_rsp("reset", 1'b0, 1'b0, 32'h0);
        end

        // CPU read granted in the first cycle out of reset.
        @(negedge clk);
        rst = 1'b0;
        drv_c(1'b1, 1'b0, 15'h005, '0, 4'h0);
        drv_l(1'b0, 1'b0, '0, '0, 4'h0);
        #1;
        chk_gnt("post-reset read", 1'b1, 1'b0);
        @(negedge clk); idle(); #1;
        chk_rsp("post-reset rsp", 1'b1, 1'b0, 32'h1234_5678);
        chk_gnt("idle", 1'b0, 1'b0);
        chk("idle mem_wren", {31'b0, mem_wren}, 32'h0);

        // CPU full write then read back.
        @(negedge clk); drv_c(1'b1, 1'b1, 15'h010, 32'hDEAD_BEEF, 4'hF); #1;
        chk_gnt("cpu write", 1'b1, 1'b0);
        chk("cpu write mem_wren", {31'b0, mem_wren}, 32'h1);
        chk("cpu write mem_be", {28'b0, mem_be}, 32'hF);
        chk("cpu write mem_addr", {17'b0, mem_addr}, 32'h10);
        @(negedge clk); drv_c(1'b1, 1'b0, 15'h010, '0, 4'h0); #1;
        chk_gnt("cpu read", 1'b1, 1'b0);
        chk_rsp("write no rsp", 1'b0, 1'b0, 32'h0);
        @(negedge clk); idle(); #1;
        chk_rsp("cpu readback", 1'b1, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        chk_rsp("rvalid one wide", 1'b0, 1'b0, 32'h0);

        // Loader partial write of byte 0, then CPU read.
        drv_l(1'b1, 1'b1, 15'h010, 32'h0000_00AA, 4'b0001); #1;
        chk_gnt("ldr write", 1'b0, 1'b1);
        chk("ldr write mem_be", {28'b0, mem_be}, 32'h1);
        chk("ldr write mem_wdata", mem_wdata, 32'h0000_00AA);
        @(negedge clk); idle(); drv_c(1'b1, 1'b0, 15'h010, '0, 4'h0); #1;
        chk_gnt("partial read", 1'b1, 1'b0);
        @(negedge clk); idle(); #1;
        chk_rsp("partial readback", 1'b1, 1'b0, 32'hDEAD_BEAA);

        // Write with no byte enables: granted, RAM unchanged.
        drv_c(1'b1, 1'b1, 15'h010, 32'h5555_5555, 4'h0); #1;
        chk_gnt("be0 write", 1'b1, 1'b0);
        chk("be0 mem_wren", {31'b0, mem_wren}, 32'h1);
        chk("be0 mem_be", {28'b0, mem_be}, 32'h0);
        @(negedge clk); drv_c(1'b1, 1'b0, 15'h010, '0, 4'h0); #1;
        @(negedge clk); idle(); #1;
        chk_rsp("be0 readback", 1'b1, 1'b0, 32'hDEAD_BEAA);

        // Starvation: both reading continuously -> C,C,C,C,L repeating.
        prev_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drv_c(1'b1, 1'b0, 15'h020, '0, 4'h0);
            drv_l(1'b1, 1'b0, 15'h030, '0, 4'h0);
            #1;
            exp_c = ((i % 5) != 4);
            chk_gnt("starve", exp_c, ~exp_c);
            if (i > 0)
                chk_rsp("starve rsp", prev_c, ~prev_c, prev_c ? 32'hC0DE_0020 : 32'h1DAD_0030);
            prev_c = exp_c;
        end
        @(negedge clk); idle(); #1;
        chk_rsp("starve last rsp", 1'b0, 1'b1, 32'h1DAD_0030);

        // Interleaved single-requester reads on consecutive cycles.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle();
            if (k % 2 == 0) drv_c(1'b1, 1'b0, 15'h040 + 15'(k), '0, 4'h0);
            else            drv_l(1'b1, 1'b0, 15'h040 + 15'(k), '0, 4'h0);
            #1;
            chk_gnt("interleave", (k % 2 == 0), (k % 2 == 1));
            if (k > 0)
                chk_rsp("interleave rsp", ((k - 1) % 2 == 0), ((k - 1) % 2 == 1),
                        32'hA500_0000 | (k - 1));
        end
        @(negedge clk); idle(); #1;
        chk_rsp("interleave last", 1'b0, 1'b1, 32'hA500_0005);

        // Build up the starvation count to 3, then reset with a CPU read in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv_c(1'b1, 1'b0, 15'h020, '0, 4'h0);
            drv_l(1'b1, 1'b0, 15'h030, '0, 4'h0);
            #1;
            chk_gnt("pre-reset", 1'b1, 1'b0);
        end
        @(negedge clk); rst = 1'b1; #1;
        chk_gnt("mid-reset", 1'b0, 1'b0);
        chk_rsp("mid-reset dropped", 1'b0, 1'b0, 32'h0);
        @(negedge clk); rst = 1'b0; #1;
        chk_rsp("after reset no rsp", 1'b0, 1'b0, 32'h0);
        // Count restarts at zero: four more CPU wins before the loader.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            chk_gnt("restarve", (i != 4), (i == 4));
        end

        @(negedge clk); idle(); rst = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port (byte-enabled synchronous RAM, one-cycle read latency) between the CPU load/store path and the memory loader/debug path. CPU has fixed priority, with a starvation counter that guarantees the loader a slot. The block also tracks outstanding reads and routes each read response back to its requester. It sits between the CPU memory stage / loader and the RAM macro; the byte-lane-aligned write data and byte-enable are prepared upstream by each requester.

## Interface
- DATA_WIDTH, 32, data bus width (byte enables are DATA_WIDTH/8 = 4 bits)
- ADDR_WIDTH, 15, word address width
- STARVE_LIMIT, 4, consecutive loader denials before the loader is forced through (1..15)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  CPU request valid
- c_we  in  1  CPU write (1) / read (0)
- c_addr  in  ADDR_WIDTH  CPU word address
- c_wdata  in  DATA_WIDTH  CPU write data, already lane-aligned
- c_be  in  4  CPU byte enables
- c_gnt  out  1  CPU request accepted this cycle
- c_rvalid  out  1  CPU read data valid
- c_rdata  out  DATA_WIDTH  CPU read data (raw word)
- l_req, l_we, l_addr, l_wdata, l_be, l_gnt, l_rvalid, l_rdata: loader port, identical widths/meaning
- mem_addr  out  ADDR_WIDTH  RAM word address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_be  out  4  RAM byte enables
- mem_wren  out  1  RAM write enable
- mem_q  in  DATA_WIDTH  RAM read data, valid the cycle after the address is presented

## Operation
- One grant per cycle at most; grant is combinational from the current request and registered state. A request is accepted in the cycle its gnt is 1; a requester holds req/addr/data stable until granted.
- Arbitration:
  - only one requester active → it wins;
  - both active and starve_cnt < STARVE_LIMIT → CPU wins, starve_cnt increments;
  - both active and starve_cnt == STARVE_LIMIT → loader wins, starve_cnt clears;
  - loader granted for any reason → starve_cnt clears;
  - loader not requesting → starve_cnt clears.
- Winner's addr/wdata/be drive mem_*; mem_wren = winner_we & grant. With no grant: mem_wren = 0, mem_be = 0, mem_addr/mem_wdata = CPU inputs (don't-care).
- Write mem_be = 0 is legal; it is granted and is a no-op in RAM.
- Read response pipeline: registered rsp_pend (1 bit) and rsp_src (0 = CPU, 1 = loader), loaded at each granted read. The cycle after, the selected rvalid = 1; both rdata outputs = mem_q (unmasked, no extension; lane select and sign extension are the requester's job).
- Writes produce no response.
- Back-to-back reads are fully pipelined, one per cycle; rsp_src updates every cycle.

## Timing
- Reset (rst high at edge): starve_cnt = 0, rsp_pend = 0. While rst is high: c_gnt = l_gnt = 0, mem_wren = 0, mem_be = 0, c_rvalid = l_rvalid = 0.
- A read granted in the cycle rst rises is dropped: no rvalid after reset.
- Read latency: grant in cycle N → rvalid in cycle N+1, exactly one cycle wide per read.
- Write latency: RAM updated at the edge ending the grant cycle. A read of the same address granted in cycle N+1 returns the new data in N+2.
- A read response in cycle N+1 and a new grant in N+1 are independent; both happen.
- Worst-case loader wait under continuous CPU traffic: STARVE_LIMIT cycles of denial, granted on the next.
- CPU wait when forced: one cycle, then normal priority resumes.

## Test plan
- Reset: drive both reqs with rst=1 for 3 cycles → gnts 0, mem_wren 0, rvalids 0. After rst drops, CPU read granted the same cycle.
- CPU write then read: CPU write addr 0x10, data 0xDEADBEEF, be 4'b1111; then read 0x10 → c_rvalid one cycle after the read grant, c_rdata = 0xDEADBEEF, l_rvalid = 0.
- Partial write: loader writes 0x000000AA, be 4'b0001 to addr 0x10 (prior 0xDEADBEEF); CPU reads → 0xDEADBEAA.
- Starvation with STARVE_LIMIT=4: c_req and l_req held high, all reads → grants C,C,C,C,L,C,C,C,C,L,… Each rvalid lands on the correct port one cycle after its grant.
- Interleaved pipelined reads: alternating CPU/loader reads of distinct preloaded addresses on consecutive cycles → each rdata/rvalid pair matches its address and source, with no gaps.
- Reset mid-read: grant a CPU read, assert rst next cycle → c_rvalid stays 0; starve_cnt returns to 0 (verified by the loader needing 4 denials again).
